text_raster_ctrl: RTL and testbench
===================================

// Module: text_raster_ctrl
// PURPOSE
//  Text-mode scan controller for the 6x8 raster font ROM. Walks a COLS x ROWS
//  character grid in step with the video timing, reads char codes from a
//  synchronous text RAM, drives char/row into the font ROM and shifts each
//  6-bit raster out as a serial pixel stream. Sits between video timing and DAC.
// PARAMETERS
//  COLS    40  characters per text row
//  ROWS    24  text rows per frame
//  ADDR_W  10  text RAM address width; must satisfy 2**ADDR_W >= COLS*ROWS
// PORTS
//  i_clk          in   1       clock
//  i_rst          in   1       reset, synchronous, active-high
//  i_frame_start  in   1       one-cycle pulse: new frame
//  i_line_start   in   1       one-cycle pulse: new active scanline, >=3 cycles before first i_pix_en
//  i_pix_en       in   1       one active pixel requested this cycle
//  o_text_addr    out  ADDR_W  text RAM address (text_row*COLS + col)
//  i_text_char    in   6       text RAM data, valid the cycle after o_text_addr
//  o_font_char    out  6       char code to font ROM (registered)
//  o_font_row     out  3       scan row within glyph to font ROM (registered)
//  i_font_raster  in   6       font ROM output, combinational from o_font_char/o_font_row
//  o_pixel        out  1       pixel value
//  o_pixel_valid  out  1       o_pixel is meaningful this cycle
//  o_underrun     out  1       sticky: pixel requested with no raster loaded
// BEHAVIOUR
//  Reset: state IDLE; col, pix_x, scan_row, text_row = 0; all outputs 0.
//  States: IDLE -> ADDR -> LOAD -> ACTIVE -> LINE_DONE -> (ADDR | FRAME_DONE).
//  - IDLE/LINE_DONE + i_line_start: -> ADDR; col=0, pix_x=0.
//  - ADDR (1 cycle): o_text_addr = text_row*COLS+col.
//  - LOAD (1 cycle): o_font_char<=i_text_char, o_font_row<=scan_row; next cycle
//    i_font_raster captured into shift reg; -> ACTIVE. First pixel available 3
//    cycles after i_line_start.
//  - ACTIVE: each i_pix_en emits shift-reg MSB (bit 5 = leftmost pixel), then
//    shifts left; pix_x++. Output latency 1: o_pixel/o_pixel_valid register the
//    cycle after i_pix_en; o_pixel_valid=0 in cycles without i_pix_en.
//  - Prefetch: on pixel pix_x==0 of char col (col<COLS-1), issue addr col+1,
//    capture char, capture raster into next buffer within 3 cycles; at pix_x==5
//    pixel, next buffer moves into shift reg, pix_x=0, col++. No bubble even
//    with i_pix_en every cycle.
//  - After pixel 5 of col COLS-1: -> LINE_DONE; scan_row++; on wrap 7->0
//    text_row++; if text_row reaches ROWS -> FRAME_DONE.
//  - FRAME_DONE: i_line_start and i_pix_en ignored (no underrun) until
//    i_frame_start.
//  - i_frame_start (any state): scan_row=text_row=0, col=pix_x=0, -> IDLE,
//    o_underrun cleared. Same cycle as i_line_start: frame reset applies, then
//    line starts -> ADDR for row 0, scan 0.
//  - i_line_start during ADDR/LOAD/ACTIVE: current line abandoned, counters
//    scan_row/text_row NOT advanced, restart at ADDR col 0.
//  - i_pix_en in IDLE/ADDR/LOAD/LINE_DONE: o_pixel_valid=1, o_pixel=0,
//    o_underrun<=1. Pixel counters unaffected.
//  - Address arithmetic: text_row*COLS+col computed in ADDR_W bits, no wrap for
//    legal params. o_font_row = scan_row[2:0].
//  - i_rst mid-line: immediate return to reset state; behaves as frame start.
// TESTING
//  1. Reset, frame_start, line_start; RAM[0]=0x01, font row0 raster 0x2A,
//     pix_en every cycle from +3 -> pixels 1,0,1,0,1,0, valid 1 cycle after en.
//  2. Full line COLS=40, pix_en continuous -> 240 valid pixels, addrs 0..39 in
//     order, no gaps, no underrun, scan_row->1.
//  3. 8 lines -> text_row 1; 9th line addresses start at 40; after 192 lines
//     FRAME_DONE, further line_start -> no addr activity, o_pixel_valid only 0.
//  4. pix_en 1 cycle after line_start -> o_pixel=0, valid=1, o_underrun=1;
//     frame_start clears it.
//  5. line_start at pixel 100 of a line -> restart col 0, same scan_row; reset
//     asserted mid-line -> all outputs 0 next cycle, next line uses addr 0.

Source files
------------

// File: rtl/text_raster_ctrl.sv
// text_raster_ctrl: text-mode scan controller for a 6x8 raster font ROM.
// Walks a COLS x ROWS character grid in step with the video timing. It fetches
// character codes from a synchronous text RAM, presents char/row to the font ROM
// and shifts each 6-bit raster out MSB-first as a serial pixel stream.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_frame_start    pulse: restart at text row 0, scan row 0; clears o_underrun
//   i_line_start     pulse: begin the next active scanline
//   i_pix_en         one pixel requested this cycle
//   o_text_addr      text RAM address (text_row*COLS + col)
//   i_text_char      text RAM data, valid the cycle after o_text_addr
//   o_font_char      char code to font ROM
//   o_font_row       glyph scan row to font ROM
//   i_font_raster    font ROM data, combinational from o_font_char/o_font_row
//   o_pixel          pixel value, one cycle after i_pix_en
//   o_pixel_valid    o_pixel is meaningful this cycle
//   o_underrun       sticky: pixel requested while no raster was loaded
module text_raster_ctrl #(
  parameter int unsigned COLS   = 40,
  parameter int unsigned ROWS   = 24,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_line_start,
  input  logic              i_pix_en,
  output logic [ADDR_W-1:0] o_text_addr,
  input  logic [5:0]        i_text_char,
  output logic [5:0]        o_font_char,
  output logic [2:0]        o_font_row,
  input  logic [5:0]        i_font_raster,
  output logic              o_pixel,
  output logic              o_pixel_valid,
  output logic              o_underrun
);

  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RowW = $clog2(ROWS + 1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StLoad, StActive, StLineDone, StFrameDone
  } state_e;

  state_e          state_q;
  logic [ColW-1:0] col_q;
  logic [2:0]      pix_x_q;
  logic [2:0]      scan_row_q;
  logic [RowW-1:0] text_row_q;
  logic [5:0]      shift_q;
  logic [5:0]      next_q;      // raster of the following character
  logic            load_pend_q; // first raster of the line is still on the ROM bus
  logic [2:0]      pf_q;        // prefetch pipeline: addr out, char in, raster in

  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] next_addr;
  logic [5:0]        cur_raster;
  logic              last_col;

  assign row_base   = ADDR_W'(text_row_q) * ADDR_W'(COLS);
  assign next_addr  = row_base + ADDR_W'(col_q) + ADDR_W'(1);
  // The first char's raster is used straight off the ROM so pixel 0 is not delayed.
  assign cur_raster = load_pend_q ? i_font_raster : shift_q;
  assign last_col   = (col_q == ColW'(COLS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      col_q         <= '0;
      pix_x_q       <= '0;
      scan_row_q    <= '0;
      text_row_q    <= '0;
      shift_q       <= '0;
      next_q        <= '0;
      load_pend_q   <= 1'b0;
      pf_q          <= '0;
      o_text_addr   <= '0;
      o_font_char   <= '0;
      o_font_row    <= '0;
      o_pixel       <= 1'b0;
      o_pixel_valid <= 1'b0;
      o_underrun    <= 1'b0;
    end else begin
      o_pixel       <= 1'b0;
      o_pixel_valid <= 1'b0;
      load_pend_q   <= 1'b0;
      pf_q          <= {pf_q[1:0], 1'b0};
      if (pf_q[1]) o_font_char <= i_text_char;
      if (pf_q[2]) next_q <= i_font_raster;

      if (i_frame_start) begin
        scan_row_q <= '0;
        text_row_q <= '0;
        col_q      <= '0;
        pix_x_q    <= '0;
        pf_q       <= '0;
        o_underrun <= 1'b0;
        if (i_line_start) begin
          state_q     <= StAddr;
          o_text_addr <= '0;
        end else begin
          state_q <= StIdle;
        end
      end else begin
        if (i_pix_en) begin
          if (state_q == StActive) begin
            o_pixel_valid <= 1'b1;
            o_pixel       <= cur_raster[5];
          end else if (state_q != StFrameDone) begin
            o_pixel_valid <= 1'b1;
            o_underrun    <= 1'b1;
          end
        end

        if (i_line_start && state_q != StFrameDone) begin
          // Abandons any line in progress without advancing the row counters.
          state_q     <= StAddr;
          col_q       <= '0;
          pix_x_q     <= '0;
          pf_q        <= '0;
          o_text_addr <= row_base;
        end else begin
          case (state_q)
            StAddr: state_q <= StLoad;
            StLoad: begin
              o_font_char <= i_text_char;
              o_font_row  <= scan_row_q;
              load_pend_q <= 1'b1;
              state_q     <= StActive;
            end
            StActive: begin
              if (i_pix_en) begin
                if (pix_x_q == 3'd5) begin
                  pix_x_q <= '0;
                  if (last_col) begin
                    scan_row_q <= scan_row_q + 3'd1;
                    if (scan_row_q == 3'd7) begin
                      text_row_q <= text_row_q + RowW'(1);
                      state_q    <= (text_row_q + RowW'(1) == RowW'(ROWS)) ? StFrameDone
                                                                           : StLineDone;
                    end else begin
                      state_q <= StLineDone;
                    end
                  end else begin
                    shift_q <= next_q;
                    col_q   <= col_q + ColW'(1);
                  end
                end else begin
                  shift_q <= {cur_raster[4:0], 1'b0};
                  pix_x_q <= pix_x_q + 3'd1;
                  // Fetch the next char while this one is shifting out.
                  if (pix_x_q == 3'd0 && !last_col) begin
                    o_text_addr <= next_addr;
                    pf_q        <= 3'b001;
                  end
                end
              end else begin
                shift_q <= cur_raster;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_text_raster_ctrl.sv
// Bench for text_raster_ctrl: a vector table for reset, first-line latency, underrun and
// frame/line start interaction, then hand-written full-frame, abandon and reset sequences.
module tb_text_raster_ctrl;

  localparam int COLS   = 40;
  localparam int ROWS   = 24;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              frame_start = 1'b0;
  logic              line_start = 1'b0;
  logic              pix_en = 1'b0;
  logic [ADDR_W-1:0] text_addr;
  logic [5:0]        text_char = '0;
  logic [5:0]        font_char;
  logic [2:0]        font_row;
  logic [5:0]        font_raster;
  logic              pixel;
  logic              pixel_valid;
  logic              underrun;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] stim; // {rst, frame_start, line_start, pix_en}
    logic [2:0] exp;  // {pixel_valid, pixel, underrun}
  } vec_t;

  vec_t vq[$];

  text_raster_ctrl #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .ADDR_W(ADDR_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_start(frame_start),
    .i_line_start (line_start),
    .i_pix_en     (pix_en),
    .o_text_addr  (text_addr),
    .i_text_char  (text_char),
    .o_font_char  (font_char),
    .o_font_row   (font_row),
    .i_font_raster(font_raster),
    .o_pixel      (pixel),
    .o_pixel_valid(pixel_valid),
    .o_underrun   (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ram_f(input int a);
    int v;
    v = a * 7 + 1;
    return v[5:0];
  endfunction

  function automatic logic [5:0] font_f(input logic [5:0] c, input logic [2:0] r);
    int v;
    if (c == 6'd1 && r == 3'd0) return 6'h2A;
    v = int'(c) * 13 + int'(r) * 7 + 5;
    return v[5:0];
  endfunction

  // Synchronous text RAM and combinational font ROM models.
  always @(posedge clk) text_char <= ram_f(int'(text_addr));
  assign font_raster = font_f(font_char, font_row);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one scanline with pix_en every cycle from 3 cycles after line_start.
  task automatic run_line(input int tr, input int sr, input int npix);
    int base, last, nval, nbad, exp_n, aerr, col, k, lim;
    logic [5:0] ras;
    int addrs[$];
    addrs.delete();
    base = tr * COLS;
    last = -1;
    nval = 0;
    nbad = 0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      if (int'(text_addr) != last) begin
        addrs.push_back(int'(text_addr));
        last = int'(text_addr);
      end
    end
    check($sformatf("r%0d s%0d font_row", tr, sr), int'(font_row), sr);
    pix_en = 1'b1;
    for (int i = 0; i < npix; i++) begin
      tick();
      if (int'(text_addr) != last) begin
        addrs.push_back(int'(text_addr));
        last = int'(text_addr);
      end
      col = i / 6;
      k   = i % 6;
      ras = font_f(ram_f(base + col), sr[2:0]);
      if (pixel_valid) nval++;
      if (!pixel_valid || pixel != ras[5-k]) nbad++;
    end
    pix_en = 1'b0;
    exp_n = (npix - 1) / 6 + 2;
    if (exp_n > COLS) exp_n = COLS;
    check($sformatf("r%0d s%0d valid count", tr, sr), nval, npix);
    check($sformatf("r%0d s%0d bad pixels", tr, sr), nbad, 0);
    check($sformatf("r%0d s%0d addr count", tr, sr), addrs.size(), exp_n);
    aerr = 0;
    lim = (addrs.size() < exp_n) ? addrs.size() : exp_n;
    for (int j = 0; j < lim; j++) if (addrs[j] != base + j) aerr++;
    check($sformatf("r%0d s%0d addr order", tr, sr), aerr, 0);
    check($sformatf("r%0d s%0d underrun", tr, sr), int'(underrun), 0);
  endtask

  initial begin
    int nval, nchg;
    // Reset, frame, first line: char 1 row 0 = 2A, then char 8 row 0 = 2D.
    vq.push_back('{4'b1000, 3'b000});
    vq.push_back('{4'b0100, 3'b000});
    vq.push_back('{4'b0010, 3'b000});
    vq.push_back('{4'b0000, 3'b000});
    vq.push_back('{4'b0000, 3'b000});
    vq.push_back('{4'b0001, 3'b110});
    vq.push_back('{4'b0001, 3'b100});
    vq.push_back('{4'b0001, 3'b110});
    vq.push_back('{4'b0001, 3'b100});
    vq.push_back('{4'b0001, 3'b110});
    vq.push_back('{4'b0001, 3'b100});
    vq.push_back('{4'b0001, 3'b110});
    vq.push_back('{4'b0001, 3'b100});
    vq.push_back('{4'b0001, 3'b110});
    vq.push_back('{4'b0001, 3'b110});
    vq.push_back('{4'b0001, 3'b100});
    vq.push_back('{4'b0001, 3'b110});
    // Underrun: pix_en one cycle after line_start; frame_start clears it.
    vq.push_back('{4'b0100, 3'b000});
    vq.push_back('{4'b0010, 3'b000});
    vq.push_back('{4'b0001, 3'b101});
    vq.push_back('{4'b0000, 3'b001});
    vq.push_back('{4'b0100, 3'b000});
    // frame_start with line_start: line starts at row 0, scan 0.
    vq.push_back('{4'b0110, 3'b000});
    vq.push_back('{4'b0000, 3'b000});
    vq.push_back('{4'b0000, 3'b000});
    vq.push_back('{4'b0001, 3'b110});
    vq.push_back('{4'b0001, 3'b100});
    vq.push_back('{4'b0001, 3'b110});

    foreach (vq[i]) begin
      {rst, frame_start, line_start, pix_en} = vq[i].stim;
      tick();
      check($sformatf("vec%0d {valid,pixel,underrun}", i),
            int'({pixel_valid, pixel, underrun}), int'(vq[i].exp));
    end
    {rst, frame_start, line_start, pix_en} = 4'b0000;

    // Full frame: 24 text rows x 8 scan rows.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int tr = 0; tr < ROWS; tr++)
      for (int sr = 0; sr < 8; sr++) run_line(tr, sr, 240);

    // Frame done: line_start and pix_en ignored.
    nval = 0;
    nchg = 0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    pix_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pixel_valid) nval++;
      if (int'(text_addr) != ROWS * COLS - 1) nchg++;
    end
    pix_en = 1'b0;
    check("frame done valid", nval, 0);
    check("frame done addr moves", nchg, 0);
    check("frame done underrun", int'(underrun), 0);

    // Line abandoned at pixel 100 restarts without advancing scan row.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    run_line(0, 0, 240);
    run_line(0, 1, 100);
    run_line(0, 1, 240);
    run_line(0, 2, 50);

    // Reset mid-line.
    rst = 1'b1;
    pix_en = 1'b1;
    tick();
    rst = 1'b0;
    pix_en = 1'b0;
    check("reset mid-line outputs",
          int'({text_addr, font_char, font_row, pixel, pixel_valid, underrun}), 0);
    run_line(0, 0, 240);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
